// File: rtl/voice_dds_scheduler_pkg.sv
// Shared types and constants for the voice DDS scheduler: field widths of the
// note/pitch/adder buses, the pitch-wheel centre value and the scheduler FSM states.
package voice_dds_scheduler_pkg;

  localparam int NOTE_W  = 7;
  localparam int PITCH_W = 14;
  localparam int ADDER_W = 32;

  localparam logic [PITCH_W-1:0] PITCH_CENTRE = 14'd8192;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/voice_dds_scheduler_rr_pick.sv
// Combinational round-robin finder: returns the first set bit of 'dirty'
// searching upward from 'rr' and wrapping modulo VOICES.
module voice_dds_scheduler_rr_pick
  import voice_dds_scheduler_pkg::*;
#(
  parameter int VOICES = 8,
  parameter int IDX_W  = $clog2(VOICES)
) (
  input  logic [VOICES-1:0] dirty,
  input  logic [IDX_W-1:0]  rr,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scan all VOICES positions starting at rr; the first dirty one wins.
  always_comb begin
    int cand;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < VOICES; k++) begin
      cand = (int'(rr) + k) % VOICES;
      if (!found && dirty[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/voice_dds_scheduler.sv
// Shares one note/pitch-to-DDS converter between VOICES voices. Voices whose
// note (or the global pitch wheel) changed are marked dirty and converted one
// at a time in round-robin order; after SETTLE cycles the converter result is
// captured into that voice's phase-increment slot.
module voice_dds_scheduler
  import voice_dds_scheduler_pkg::*;
#(
  parameter int VOICES = 8,
  parameter int SETTLE = 8,
  localparam int IDX_W = $clog2(VOICES)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NOTE_W*VOICES-1:0]  VOICE_NOTES,
  input  logic [PITCH_W-1:0]        PITCH,
  output logic [NOTE_W-1:0]         CONV_NOTE,
  output logic [PITCH_W-1:0]        CONV_PITCH,
  input  logic [ADDER_W-1:0]        CONV_ADDER,
  output logic [ADDER_W*VOICES-1:0] VOICE_ADDERS,
  output logic                      UPD_STROBE,
  output logic [IDX_W-1:0]          UPD_VOICE,
  output logic                      BUSY
);

  localparam int CNT_W = $clog2(SETTLE);

  logic [NOTE_W-1:0]  note_in     [VOICES];
  logic [NOTE_W-1:0]  note_shadow [VOICES];
  logic [PITCH_W-1:0] pitch_shadow;
  logic               pitch_chg;
  logic [VOICES-1:0]  dirty;
  logic [VOICES-1:0]  dirty_set;
  logic [VOICES-1:0]  dirty_clr;

  state_t             state;
  logic [IDX_W-1:0]   cur;
  logic [IDX_W-1:0]   rr;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic [ADDER_W-1:0] slot [VOICES];

  // Next round-robin start position after serving voice v.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(VOICES-1)) return '0;
    return v + 1'b1;
  endfunction

  // Split the packed note bus into per-voice fields.
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      note_in[i] = VOICE_NOTES[NOTE_W*i +: NOTE_W];
    end
  end

  // Change detection against the shadows, and the dirty bit cleared on LOAD.
  always_comb begin
    pitch_chg = (PITCH != pitch_shadow);
    dirty_set = '0;
    dirty_clr = '0;
    for (int i = 0; i < VOICES; i++) begin
      dirty_set[i] = pitch_chg || (note_in[i] != note_shadow[i]);
    end
    if (state == S_LOAD) dirty_clr[cur] = 1'b1;
  end

  // Shadows track the inputs every cycle so each change is seen exactly once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < VOICES; i++) note_shadow[i] <= '0;
      pitch_shadow <= PITCH_CENTRE;
    end else begin
      for (int i = 0; i < VOICES; i++) note_shadow[i] <= note_in[i];
      pitch_shadow <= PITCH;
    end
  end

  // Dirty register: a new change wins over the LOAD clear in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) dirty <= '1;
    else       dirty <= (dirty & ~dirty_clr) | dirty_set;
  end

  voice_dds_scheduler_rr_pick #(
    .VOICES (VOICES),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .dirty  (dirty),
    .rr     (rr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Scheduler FSM: pick a dirty voice, present it, wait for settle, capture.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cur        <= '0;
      rr         <= '0;
      cnt        <= '0;
      CONV_NOTE  <= '0;
      CONV_PITCH <= PITCH_CENTRE;
      UPD_STROBE <= 1'b0;
      UPD_VOICE  <= '0;
    end else begin
      UPD_STROBE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            cur   <= pick_idx;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          CONV_NOTE  <= note_in[cur];
          CONV_PITCH <= PITCH;
          cnt        <= CNT_W'(SETTLE-1);
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        end
        S_CAPTURE: begin
          UPD_STROBE <= 1'b1;
          UPD_VOICE  <= cur;
          rr         <= next_idx(cur);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Phase-increment slots: only the voice being captured is written.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < VOICES; i++) slot[i] <= '0;
    end else if (state == S_CAPTURE) begin
      slot[cur] <= CONV_ADDER;
    end
  end

  // Pack slots onto the output bus.
  always_comb begin
    VOICE_ADDERS = '0;
    for (int i = 0; i < VOICES; i++) begin
      VOICE_ADDERS[ADDER_W*i +: ADDER_W] = slot[i];
    end
  end

  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_voice_dds_scheduler.sv
// Bench for voice_dds_scheduler: converter model (NOTE*65536+PITCH, 5-cycle
// latency), directed scenarios and a randomized phase checked against a
// behavioural model built from input history and the per-voice service time.
`timescale 1ns/1ps
module tb_voice_dds_scheduler;

  localparam int VOICES = 4;
  localparam int SETTLE = 8;
  localparam int IDX_W  = 2;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [7*VOICES-1:0]   VOICE_NOTES;
  logic [13:0]           PITCH;
  logic [6:0]            CONV_NOTE;
  logic [13:0]           CONV_PITCH;
  logic [31:0]           CONV_ADDER;
  logic [32*VOICES-1:0]  VOICE_ADDERS;
  logic                  UPD_STROBE;
  logic [IDX_W-1:0]      UPD_VOICE;
  logic                  BUSY;

  voice_dds_scheduler #(
    .VOICES (VOICES),
    .SETTLE (SETTLE)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .VOICE_NOTES  (VOICE_NOTES),
    .PITCH        (PITCH),
    .CONV_NOTE    (CONV_NOTE),
    .CONV_PITCH   (CONV_PITCH),
    .CONV_ADDER   (CONV_ADDER),
    .VOICE_ADDERS (VOICE_ADDERS),
    .UPD_STROBE   (UPD_STROBE),
    .UPD_VOICE    (UPD_VOICE),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] conv_fn(input int n, input int p);
    return 32'(n) * 32'd65536 + 32'(p);
  endfunction

  function automatic logic [31:0] slot_of(input int v);
    return VOICE_ADDERS[32*v +: 32];
  endfunction

  // Converter model: result appears 5 cycles after its inputs change.
  logic [31:0] conv_pipe [5];
  initial for (int i = 0; i < 5; i++) conv_pipe[i] = '0;
  always @(posedge CLK) begin
    conv_pipe[0] <= conv_fn(int'(CONV_NOTE), int'(CONV_PITCH));
    for (int i = 1; i < 5; i++) conv_pipe[i] <= conv_pipe[i-1];
  end
  assign CONV_ADDER = conv_pipe[4];

  // Input history per clock edge, so each result can be tied to its snapshot.
  logic [7*VOICES-1:0] hist_n [16];
  logic [13:0]         hist_p [16];
  int                  edge_no = 0;
  always @(posedge CLK) begin
    hist_n[edge_no % 16] = VOICE_NOTES;
    hist_p[edge_no % 16] = PITCH;
    edge_no = edge_no + 1;
  end

  // Expected slot contents and the observed service sequence.
  logic [31:0] exp_slot [VOICES];
  int          served_q[$];
  int          served_edge[$];
  logic [31:0] served_val[$];
  int          last_strobe_edge = -1;

  // Monitor: an update must carry the value for the snapshot taken at its LOAD
  // (9 edges before the capture edge) and must leave all other slots alone.
  always @(negedge CLK) begin
    int v;
    int si;
    logic [31:0] ev;
    if (!RESET && UPD_STROBE) begin
      v  = int'(UPD_VOICE);
      si = (edge_no - 10) % 16;
      ev = conv_fn(int'(hist_n[si][7*v +: 7]), int'(hist_p[si]));
      check_eq("upd_value", slot_of(v), ev);
      exp_slot[v] = ev;
      for (int i = 0; i < VOICES; i++) check_eq("slot_hold", slot_of(i), exp_slot[i]);
      if (last_strobe_edge >= 0)
        check_eq("upd_gap_min", 64'((edge_no - last_strobe_edge) >= SETTLE + 3), 64'd1);
      last_strobe_edge = edge_no;
      served_q.push_back(v);
      served_edge.push_back(edge_no);
      served_val.push_back(ev);
    end
  end

  int note_v [VOICES];
  int pitch_v;

  task automatic drive();
    for (int i = 0; i < VOICES; i++) VOICE_NOTES[7*i +: 7] = 7'(note_v[i]);
    PITCH = 14'(pitch_v);
  endtask

  task automatic clear_log();
    served_q.delete();
    served_edge.delete();
    served_val.delete();
  endtask

  task automatic wait_quiet(input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge CLK);
      n++;
      if (!BUSY) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_settled"}, 64'(quiet >= 4), 64'd1);
  endtask

  task automatic check_order(input string tag, input int n, input int s [4]);
    check_eq({tag, "_count"}, 64'(served_q.size()), 64'(n));
    for (int i = 0; i < n && i < served_q.size(); i++)
      check_eq({tag, "_voice"}, 64'(served_q[i]), 64'(s[i]));
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < served_edge.size(); i++)
      check_eq({tag, "_gap"}, 64'(served_edge[i] - served_edge[i-1]), 64'(SETTLE + 3));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, 64'(BUSY), 64'd0);
    check_eq({tag, "_strobe"}, 64'(UPD_STROBE), 64'd0);
    check_eq({tag, "_voice"}, 64'(UPD_VOICE), 64'd0);
    check_eq({tag, "_conv_note"}, 64'(CONV_NOTE), 64'd0);
    check_eq({tag, "_conv_pitch"}, 64'(CONV_PITCH), 64'd8192);
    for (int i = 0; i < VOICES; i++) check_eq({tag, "_slot"}, 64'(slot_of(i)), 64'd0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < VOICES; i++) exp_slot[i] = '0;
    last_strobe_edge = -1;
    clear_log();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int dly;
    RESET = 1'b1;
    note_v = '{60, 64, 67, 72};
    pitch_v = 8192;
    drive();
    reset_model();
    repeat (3) @(negedge CLK);
    check_reset("rst");

    // Scenario 1: full refresh after reset release.
    RESET = 1'b0;
    wait_quiet("s1");
    check_order("s1", 4, '{0, 1, 2, 3});
    check_gaps("s1");
    check_eq("s1_slot0", 64'(slot_of(0)), 64'd3940352);
    check_eq("s1_slot3", 64'(slot_of(3)), 64'd4726784);

    // Scenario 2: single note change.
    clear_log();
    note_v[2] = 69;
    drive();
    wait_quiet("s2");
    check_order("s2", 1, '{2, 0, 0, 0});
    check_eq("s2_slot2", 64'(slot_of(2)), 64'd4530176);
    check_eq("s2_slot0", 64'(slot_of(0)), 64'd3940352);

    // Scenario 3: pitch change refreshes all, starting at rr (=3).
    clear_log();
    pitch_v = 10000;
    drive();
    wait_quiet("s3");
    check_order("s3", 4, '{3, 0, 1, 2});
    check_eq("s3_slot0", 64'(slot_of(0)), 64'd3942160);

    // Scenario 4: note change while voice 1 is in WAIT.
    clear_log();
    note_v[1] = 65;
    drive();
    repeat (6) @(negedge CLK);
    check_eq("s4_busy_mid", 64'(BUSY), 64'd1);
    note_v[1] = 66;
    drive();
    wait_quiet("s4");
    check_order("s4", 2, '{1, 1, 0, 0});
    if (served_val.size() > 0)
      check_eq("s4_stale", 64'(served_val[0]), 64'(conv_fn(65, 10000)));
    check_eq("s4_final", 64'(slot_of(1)), 64'(conv_fn(66, 10000)));

    // Scenario 5: voices 0 and 3 dirty together with rr=1.
    clear_log();
    note_v[0] = 61;
    drive();
    wait_quiet("s5a");
    check_order("s5a", 1, '{0, 0, 0, 0});
    clear_log();
    note_v[0] = 62;
    note_v[3] = 73;
    drive();
    wait_quiet("s5");
    check_order("s5", 2, '{3, 0, 0, 0});

    // Scenario 6: reset pulsed mid-WAIT, then full refresh.
    clear_log();
    pitch_v = 9000;
    drive();
    repeat (6) @(negedge CLK);
    check_eq("s6_busy_mid", 64'(BUSY), 64'd1);
    RESET = 1'b1;
    reset_model();
    #1;
    check_reset("s6_rst");
    @(negedge CLK);
    RESET = 1'b0;
    wait_quiet("s6");
    check_order("s6", 4, '{0, 1, 2, 3});
    check_gaps("s6");
    for (int i = 0; i < VOICES; i++)
      check_eq("s6_slot", 64'(slot_of(i)), 64'(conv_fn(note_v[i], pitch_v)));

    // Randomized phase: arbitrary changes at arbitrary times.
    clear_log();
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: note_v[$urandom_range(0, VOICES-1)] = int'($urandom_range(0, 127));
        1: pitch_v = int'($urandom_range(0, 16383));
        2: begin
          note_v[$urandom_range(0, VOICES-1)] = int'($urandom_range(0, 127));
          note_v[$urandom_range(0, VOICES-1)] = int'($urandom_range(0, 127));
        end
        default: ;
      endcase
      drive();
      dly = int'($urandom_range(0, 25));
      repeat (dly) @(negedge CLK);
    end
    wait_quiet("rand");
    for (int i = 0; i < VOICES; i++)
      check_eq("rand_final", 64'(slot_of(i)), 64'(conv_fn(note_v[i], pitch_v)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
